// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation encodings ({J,K}) and the helper that derives them
// from a bit's present and next value.
package jk_mod_counter_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Only HOLD/RST/SET are ever produced; an unchanged bit always maps to HOLD.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    jk_excite = {~cur & nxt, cur & ~nxt};
  endfunction

endpackage

// File: rtl/jk_mod_counter_jkff.sv
// Single JK flip-flop cell with asynchronous active-high clear.
module jk_mod_counter_jkff
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_RST:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TGL:  q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives in JK cells; the next count
// is computed here and turned into per-bit J/K excitation.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] n_d;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;
  logic             wrap_d;
  logic             wrap_q;
  logic             load_ok;

  // Widened compare so MODULUS == 2**WIDTH accepts every load value.
  assign load_ok = ({1'b0, load_val} < MOD_W);

  always_comb begin
    n_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      n_d = load_ok ? load_val : '0;
    end else if (en) begin
      if (up) begin
        if (q_q == MAX_C) begin
          n_d    = '0;
          wrap_d = 1'b1;
        end else begin
          n_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          n_d    = MAX_C;
          wrap_d = 1'b1;
        end else begin
          n_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign {j_w[gi], k_w[gi]} = jk_excite(q_q[gi], n_d[gi]);

    jk_mod_counter_jkff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j_w[gi]),
      .k     (k_w[gi]),
      .q     (q_q[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign tc   = en & ~load & ((up & (q_q == MAX_C)) | (~up & (q_q == '0)));
  assign q    = q_q;
  assign wrap = wrap_q;

endmodule
